// File: rtl/cp0_pkg.sv
// Shared CP0 definitions: register numbers, exception codes, Status/Cause bit
// positions and the exception FSM encoding.
package cp0_pkg;

    localparam logic [31:0] EXC_VECTOR = 32'h8000_0180;
    localparam int          NUM_HW_INT = 6;

    localparam logic [4:0] CP0_COUNT   = 5'd9;
    localparam logic [4:0] CP0_COMPARE = 5'd11;
    localparam logic [4:0] CP0_STATUS  = 5'd12;
    localparam logic [4:0] CP0_CAUSE   = 5'd13;
    localparam logic [4:0] CP0_EPC     = 5'd14;

    localparam logic [4:0] EXC_INT = 5'd0;
    localparam logic [4:0] EXC_OV  = 5'd12;

    localparam int ST_IE     = 0;
    localparam int ST_EXL    = 1;
    localparam int ST_IM_LO  = 10;
    localparam int ST_IM_HI  = 15;
    localparam int CA_EXC_LO = 2;
    localparam int CA_EXC_HI = 6;
    localparam int CA_IP_LO  = 10;
    localparam int CA_IP_HI  = 15;
    localparam int CA_BD     = 31;

    typedef enum logic {
        S_RUN  = 1'b0,
        S_TRAP = 1'b1
    } cp0_state_e;

endpackage

// File: rtl/cp0_int_sync.sv
// Two-flop synchronizer for the external interrupt request lines.
module cp0_int_sync
    import cp0_pkg::*;
#(
    parameter int W = NUM_HW_INT
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] async_in,
    output logic [W-1:0] sync_out
);

    logic [W-1:0] meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta     <= '0;
            sync_out <= '0;
        end else begin
            meta     <= async_in;
            sync_out <= meta;
        end
    end

endmodule

// File: rtl/cp0_exc_ctrl.sv
// CP0 exception/interrupt controller: Status/Cause/EPC, trap entry, eret and
// mtc0/mfc0. Define CP0_TIMER_EN to add the Count/Compare timer on IP[15].
//
// state  | meaning
// S_RUN  | normal execution; traps, eret and mtc0 are accepted
// S_TRAP | one-cycle flush/redirect; EX instruction is being killed
module cp0_exc_ctrl
    import cp0_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ex_valid,
    input  logic                  ex_overflow,
    input  logic [31:0]           ex_pc,
    input  logic                  ex_in_delay_slot,
    input  logic [NUM_HW_INT-1:0] hw_int,
    input  logic                  mtc0_we,
    input  logic [4:0]            cp0_addr,
    input  logic [31:0]           cp0_wdata,
    output logic [31:0]           cp0_rdata,
    input  logic                  eret,
    output logic                  flush,
    output logic [31:0]           redirect_pc
);

    cp0_state_e state, state_nxt;

    logic [5:0]  status_im;
    logic        status_exl;
    logic        status_ie;
    logic        cause_bd;
    logic [4:0]  cause_exc;
    logic [31:0] epc;

    logic [NUM_HW_INT-1:0] ip_sync;
    logic [NUM_HW_INT-1:0] ip;

    logic ov_take, int_take, trap_take, eret_take, wr_en;

    cp0_int_sync #(.W(NUM_HW_INT)) u_sync (
        .clk      (clk),
        .rst      (rst),
        .async_in (hw_int),
        .sync_out (ip_sync)
    );

`ifdef CP0_TIMER_EN
    logic [31:0] count;
    logic [31:0] compare;
    logic        timer_pend;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count      <= '0;
            compare    <= '0;
            timer_pend <= 1'b0;
        end else begin
            count <= (wr_en && cp0_addr == CP0_COUNT) ? cp0_wdata : count + 32'd1;
            // A Compare write acknowledges the timer even if Count matches now.
            if (wr_en && cp0_addr == CP0_COMPARE) begin
                compare    <= cp0_wdata;
                timer_pend <= 1'b0;
            end else if (count == compare) begin
                timer_pend <= 1'b1;
            end
        end
    end

    assign ip = {ip_sync[5] | timer_pend, ip_sync[4:0]};
`else
    assign ip = ip_sync;
`endif

    assign ov_take  = ex_valid & ex_overflow;
    assign int_take = ex_valid & status_ie & ~status_exl & (|(ip & status_im));

    always_comb begin
        state_nxt = state;
        trap_take = 1'b0;
        eret_take = 1'b0;
        wr_en     = 1'b0;
        case (state)
            S_RUN: begin
                trap_take = ov_take | int_take;
                eret_take = eret & ~trap_take;
                wr_en     = mtc0_we & ~trap_take;
                if (trap_take || eret_take)
                    state_nxt = S_TRAP;
            end
            S_TRAP:  state_nxt = S_RUN;
            default: state_nxt = S_RUN;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_RUN;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            status_im   <= '0;
            status_exl  <= 1'b0;
            status_ie   <= 1'b0;
            cause_bd    <= 1'b0;
            cause_exc   <= '0;
            epc         <= '0;
            flush       <= 1'b0;
            redirect_pc <= '0;
        end else begin
            flush <= trap_take | eret_take;
            if (trap_take)
                redirect_pc <= EXC_VECTOR;
            else if (eret_take)
                redirect_pc <= epc;

            if (wr_en) begin
                case (cp0_addr)
                    CP0_STATUS: begin
                        status_im  <= cp0_wdata[ST_IM_HI:ST_IM_LO];
                        status_exl <= cp0_wdata[ST_EXL];
                        status_ie  <= cp0_wdata[ST_IE];
                    end
                    CP0_CAUSE: begin
                        cause_bd  <= cp0_wdata[CA_BD];
                        cause_exc <= cp0_wdata[CA_EXC_HI:CA_EXC_LO];
                    end
                    CP0_EPC: epc <= cp0_wdata;
                    default: ;
                endcase
            end

            // eret's EXL clear takes precedence over a same-cycle Status write.
            if (trap_take) begin
                status_exl <= 1'b1;
                cause_bd   <= ex_in_delay_slot;
                epc        <= ex_in_delay_slot ? ex_pc - 32'd4 : ex_pc;
                cause_exc  <= ov_take ? EXC_OV : EXC_INT;
            end else if (eret_take) begin
                status_exl <= 1'b0;
            end
        end
    end

    always_comb begin
        cp0_rdata = '0;
        case (cp0_addr)
            CP0_STATUS: cp0_rdata = {16'b0, status_im, 8'b0, status_exl, status_ie};
            CP0_CAUSE:  cp0_rdata = {cause_bd, 15'b0, ip, 3'b0, cause_exc, 2'b0};
            CP0_EPC:    cp0_rdata = epc;
`ifdef CP0_TIMER_EN
            CP0_COUNT:   cp0_rdata = count;
            CP0_COMPARE: cp0_rdata = compare;
`endif
            default:    cp0_rdata = '0;
        endcase
    end

endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// Self-checking bench for cp0_exc_ctrl: directed scenarios plus a randomized
// run against a cycle-level reference model of the CP0 trap rules.
module tb_cp0_exc_ctrl;
    import cp0_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid, ex_overflow, ex_in_delay_slot;
    logic [31:0] ex_pc;
    logic [5:0]  hw_int;
    logic        mtc0_we;
    logic [4:0]  cp0_addr;
    logic [31:0] cp0_wdata;
    logic [31:0] cp0_rdata;
    logic        eret;
    logic        flush;
    logic [31:0] redirect_pc;

    int checks   = 0;
    int failures = 0;

    cp0_exc_ctrl dut (
        .clk              (clk),
        .rst              (rst),
        .ex_valid         (ex_valid),
        .ex_overflow      (ex_overflow),
        .ex_pc            (ex_pc),
        .ex_in_delay_slot (ex_in_delay_slot),
        .hw_int           (hw_int),
        .mtc0_we          (mtc0_we),
        .cp0_addr         (cp0_addr),
        .cp0_wdata        (cp0_wdata),
        .cp0_rdata        (cp0_rdata),
        .eret             (eret),
        .flush            (flush),
        .redirect_pc      (redirect_pc)
    );

    always #5 clk = ~clk;

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        ex_valid = 1'b0; ex_overflow = 1'b0; ex_in_delay_slot = 1'b0; ex_pc = '0;
        mtc0_we = 1'b0; cp0_wdata = '0; eret = 1'b0; cp0_addr = CP0_STATUS;
    endtask

    task automatic do_reset();
        rst = 1'b1; idle(); hw_int = '0;
        tick(); tick();
        rst = 1'b0;
    endtask

    task automatic write_cp0(input logic [4:0] a, input logic [31:0] d);
        mtc0_we = 1'b1; cp0_addr = a; cp0_wdata = d;
        tick();
        mtc0_we = 1'b0;
    endtask

    task automatic read_cp0(input logic [4:0] a, output logic [31:0] d);
        cp0_addr = a;
        #1;
        d = cp0_rdata;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        do_reset();
        ex_valid = 1'b1; ex_overflow = 1'b1; ex_pc = 32'h0040_0010;
        tick(); idle();
        checks++;
        if (flush !== 1'b1) begin failures++; $display("FAIL reset_preflush: got %b expected 1", flush); end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (flush !== 1'b0) begin failures++; $display("FAIL reset_flush: got %b expected 0", flush); end
        checks++;
        if (redirect_pc !== 32'h0) begin failures++; $display("FAIL reset_redirect: got %h expected 0", redirect_pc); end
        for (int r = 12; r <= 14; r++) begin
            read_cp0(5'(r), d);
            checks++;
            if (d !== 32'h0) begin failures++; $display("FAIL reset_reg%0d: got %h expected 0", r, d); end
        end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic run_overflow(input logic [31:0] pc, input logic bd, input logic [31:0] exp_epc);
        logic [31:0] d;
        do_reset();
        ex_valid = 1'b1; ex_overflow = 1'b1; ex_pc = pc; ex_in_delay_slot = bd;
        tick(); idle();
        checks++;
        if (flush !== 1'b1) begin failures++; $display("FAIL ov_flush: got %b expected 1", flush); end
        checks++;
        if (redirect_pc !== EXC_VECTOR) begin failures++; $display("FAIL ov_redirect: got %h expected %h", redirect_pc, EXC_VECTOR); end
        read_cp0(CP0_EPC, d);
        checks++;
        if (d !== exp_epc) begin failures++; $display("FAIL ov_epc: got %h expected %h", d, exp_epc); end
        read_cp0(CP0_CAUSE, d);
        checks++;
        if (d[6:2] !== 5'd12 || d[31] !== bd) begin failures++; $display("FAIL ov_cause: got %h expected exccode 12 bd %b", d, bd); end
        read_cp0(CP0_STATUS, d);
        checks++;
        if (d[1] !== 1'b1) begin failures++; $display("FAIL ov_exl: got %b expected 1", d[1]); end
        tick();
        checks++;
        if (flush !== 1'b0) begin failures++; $display("FAIL ov_flush_one_cycle: got %b expected 0", flush); end
    endtask

    task automatic test_overflow();
        run_overflow(32'h0040_0010, 1'b0, 32'h0040_0010);
        run_overflow(32'h0040_0020, 1'b1, 32'h0040_001C);
    endtask

    task automatic test_interrupt_eret();
        logic [31:0] d;
        logic seen;
        do_reset();
        write_cp0(CP0_STATUS, 32'h0000_0401);
        hw_int = 6'b000001; ex_valid = 1'b1; ex_pc = 32'h0040_0100;
        for (int i = 1; i <= 3; i++) begin
            tick();
            checks++;
            if (flush !== (i == 3)) begin failures++; $display("FAIL int_edge%0d: got %b expected %b", i, flush, (i == 3)); end
        end
        hw_int = '0; ex_valid = 1'b0;
        read_cp0(CP0_CAUSE, d);
        checks++;
        if (d[6:2] !== 5'd0) begin failures++; $display("FAIL int_exccode: got %0d expected 0", d[6:2]); end
        read_cp0(CP0_EPC, d);
        checks++;
        if (d !== 32'h0040_0100) begin failures++; $display("FAIL int_epc: got %h expected 00400100", d); end
        tick();
        eret = 1'b1;
        tick();
        eret = 1'b0;
        checks++;
        if (flush !== 1'b1 || redirect_pc !== 32'h0040_0100) begin
            failures++; $display("FAIL eret_redirect: got flush %b pc %h expected 1 00400100", flush, redirect_pc);
        end
        read_cp0(CP0_STATUS, d);
        checks++;
        if (d !== 32'h0000_0401) begin failures++; $display("FAIL eret_status: got %h expected 00000401", d); end
        tick();
        checks++;
        if (flush !== 1'b0) begin failures++; $display("FAIL eret_one_cycle: got %b expected 0", flush); end

        do_reset();
        write_cp0(CP0_STATUS, 32'h0000_0400);
        hw_int = 6'b000001; ex_valid = 1'b1; ex_pc = 32'h0040_0100;
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin tick(); seen |= flush; end
        hw_int = '0; idle();
        checks++;
        if (seen !== 1'b0) begin failures++; $display("FAIL int_ie0: got flush %b expected 0", seen); end
    endtask

    task automatic test_trap_vs_mtc0();
        logic [31:0] d;
        do_reset();
        write_cp0(CP0_EPC, 32'h0000_1234);
        ex_valid = 1'b1; ex_overflow = 1'b1; ex_pc = 32'h0040_0200;
        mtc0_we = 1'b1; cp0_addr = CP0_EPC; cp0_wdata = 32'hDEAD_BEEF;
        tick();
        ex_valid = 1'b0; ex_overflow = 1'b0;
        cp0_wdata = 32'h5555_5555;
        tick();
        mtc0_we = 1'b0;
        read_cp0(CP0_EPC, d);
        checks++;
        if (d !== 32'h0040_0200) begin failures++; $display("FAIL trap_mtc0_epc: got %h expected 00400200", d); end
        idle();
    endtask

    task automatic test_back_to_back();
        logic [31:0] d;
        do_reset();
        ex_valid = 1'b1; ex_overflow = 1'b1; eret = 1'b1; ex_pc = 32'h0040_0300;
        tick();
        eret = 1'b0;
        checks++;
        if (flush !== 1'b1 || redirect_pc !== EXC_VECTOR) begin
            failures++; $display("FAIL b2b_first: got flush %b pc %h expected 1 %h", flush, redirect_pc, EXC_VECTOR);
        end
        ex_pc = 32'h0040_0304;
        tick();
        read_cp0(CP0_EPC, d);
        checks++;
        if (flush !== 1'b0 || d !== 32'h0040_0300) begin failures++; $display("FAIL b2b_ignored: got flush %b epc %h expected 0 00400300", flush, d); end
        ex_pc = 32'h0040_0308;
        tick();
        idle();
        read_cp0(CP0_EPC, d);
        checks++;
        if (flush !== 1'b1 || d !== 32'h0040_0308) begin failures++; $display("FAIL b2b_second: got flush %b epc %h expected 1 00400308", flush, d); end
    endtask

    task automatic test_random();
        logic        m_ie, m_exl, m_bd, m_busy, m_flush;
        logic [5:0]  m_im;
        logic [4:0]  m_exc;
        logic [31:0] m_epc, m_redir, exp_rd;
        logic [5:0]  hist[$];
        logic [5:0]  ip_vis;
        logic        ov, intr;
        int          sel;
        do_reset();
`ifdef CP0_TIMER_EN
        write_cp0(CP0_COMPARE, 32'hFFFF_FFFF);
`endif
        tick(); tick();
        m_ie = 0; m_exl = 0; m_bd = 0; m_busy = 0; m_im = '0; m_exc = '0; m_epc = '0; m_redir = '0;
        hist = '{6'd0, 6'd0};
        for (int cyc = 0; cyc < 600; cyc++) begin
            ex_valid = ($urandom_range(0, 3) != 0);
            ex_overflow = ($urandom_range(0, 9) == 0);
            ex_pc = $urandom;
            ex_in_delay_slot = $urandom_range(0, 1);
            if ($urandom_range(0, 3) == 0) hw_int = 6'($urandom);
            eret = ($urandom_range(0, 7) == 0);
            mtc0_we = !eret && ($urandom_range(0, 4) == 0);
            sel = $urandom_range(0, 3);
            cp0_addr = (sel == 0) ? CP0_STATUS : (sel == 1) ? CP0_CAUSE : (sel == 2) ? CP0_EPC : 5'd3;
            if (mtc0_we) cp0_addr = ($urandom_range(0, 1) != 0) ? CP0_STATUS : CP0_EPC;
            cp0_wdata = $urandom;
            #1;
            ip_vis = hist[1];
            case (cp0_addr)
                CP0_STATUS: exp_rd = (32'(m_im) << 10) | (32'(m_exl) << 1) | 32'(m_ie);
                CP0_CAUSE:  exp_rd = (32'(m_bd) << 31) | (32'(ip_vis) << 10) | (32'(m_exc) << 2);
                CP0_EPC:    exp_rd = m_epc;
                default:    exp_rd = 32'h0;
            endcase
            checks++;
            if (cp0_rdata !== exp_rd) begin failures++; $display("FAIL rand_read cyc %0d addr %0d: got %h expected %h", cyc, cp0_addr, cp0_rdata, exp_rd); end

            m_flush = 1'b0;
            if (m_busy) begin
                m_busy = 1'b0;
            end else begin
                ov = ex_valid && ex_overflow;
                intr = ex_valid && m_ie && !m_exl && ((ip_vis & m_im) != 0);
                if (ov || intr) begin
                    m_exl = 1'b1; m_bd = ex_in_delay_slot;
                    m_epc = ex_in_delay_slot ? ex_pc - 32'd4 : ex_pc;
                    m_exc = ov ? 5'd12 : 5'd0;
                    m_flush = 1'b1; m_redir = EXC_VECTOR;
                end else begin
                    if (mtc0_we && cp0_addr == CP0_STATUS) begin
                        m_im = cp0_wdata[15:10]; m_exl = cp0_wdata[1]; m_ie = cp0_wdata[0];
                    end
                    if (mtc0_we && cp0_addr == CP0_EPC) m_epc = cp0_wdata;
                    if (eret) begin
                        m_exl = 1'b0; m_flush = 1'b1; m_redir = m_epc;
                    end
                end
                m_busy = m_flush;
            end
            hist.push_front(hw_int);
            void'(hist.pop_back());
            tick();
            checks++;
            if (flush !== m_flush || (m_flush && redirect_pc !== m_redir)) begin
                failures++; $display("FAIL rand_flush cyc %0d: got %b/%h expected %b/%h", cyc, flush, redirect_pc, m_flush, m_redir);
            end
        end
        idle(); hw_int = '0;
    endtask

`ifdef CP0_TIMER_EN
    task automatic test_timer();
        logic [31:0] d;
        logic seen;
        do_reset();
        write_cp0(CP0_COMPARE, 32'd5);
        write_cp0(CP0_STATUS, 32'h0000_8001);
        ex_valid = 1'b1; ex_pc = 32'h0040_0400;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin tick(); seen = flush; end
        idle();
        checks++;
        if (seen !== 1'b1) begin failures++; $display("FAIL timer_int: got %b expected 1", seen); end
        read_cp0(CP0_CAUSE, d);
        checks++;
        if (d[15] !== 1'b1 || d[6:2] !== 5'd0) begin failures++; $display("FAIL timer_cause: got %h expected ip15=1 exc=0", d); end
        tick();
        write_cp0(CP0_COMPARE, 32'hFFFF_0000);
        read_cp0(CP0_CAUSE, d);
        checks++;
        if (d[15] !== 1'b0) begin failures++; $display("FAIL timer_clear: got %b expected 0", d[15]); end
    endtask
`endif

    initial begin
        rst = 1'b1; hw_int = '0; idle();
        test_reset();
        test_overflow();
        test_interrupt_eret();
        test_trap_vs_mtc0();
        test_back_to_back();
        test_random();
`ifdef CP0_TIMER_EN
        test_timer();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cp0_exc_ctrl.md
# cp0_exc_ctrl

Coprocessor-0 exception and interrupt controller for the pipelined MIPS core. It consumes the EX-stage arithmetic overflow flag and the external hardware interrupt lines. On a trap it records Status, Cause and EPC, then issues a one-cycle pipeline flush with a redirect to the exception vector. It also services mtc0/mfc0 and eret, returning execution to EPC.

## Interface
- EXC_VECTOR, 32'h8000_0180, handler entry address driven on redirect_pc for every trap
- NUM_HW_INT, 6, number of external interrupt lines (maps to Cause.IP[15:10])
- clk  in  1  core clock
- rst  in  1  asynchronous, active-high reset
- ex_valid  in  1  EX stage holds a real (non-bubble) instruction
- ex_overflow  in  1  ALU overflow for EX instruction (already qualified by signed add/sub)
- ex_pc  in  32  PC of EX instruction
- ex_in_delay_slot  in  1  EX instruction sits in a branch delay slot
- hw_int  in  NUM_HW_INT  asynchronous device interrupt requests, level, active-high
- mtc0_we  in  1  write CP0 register cp0_addr with cp0_wdata (EX stage)
- cp0_addr  in  5  CP0 register number
- cp0_wdata  in  32  mtc0 data
- cp0_rdata  out  32  mfc0 data, combinational from cp0_addr
- eret  in  1  eret instruction valid in EX
- flush  out  1  kill IF/ID/EX, registered
- redirect_pc  out  32  next fetch PC while flush=1, registered

## Operation
- Registers: Status(12): IM[15:10], EXL[1], IE[0]. Cause(13): BD[31], IP[15:10] read-only, ExcCode[6:2]. EPC(14). Unimplemented addresses read 0; writes to them are ignored.
- FSM states RUN and TRAP. RUN→TRAP on accepted trap or eret; TRAP→RUN unconditionally after one cycle.
- Trap acceptance in RUN, priority order:
  - Overflow: ex_valid & ex_overflow. ExcCode=12, EPC=PC of faulting instruction.
  - Interrupt: ex_valid & IE & ~EXL & |(IP & IM). ExcCode=0, EPC=ex_pc; the EX instruction is squashed and re-executed after return.
- On trap:
  - EXL←1.
  - BD←ex_in_delay_slot.
  - EPC←ex_pc−4 if BD, else ex_pc (32-bit wrap).
  - Next cycle: flush=1, redirect_pc=EXC_VECTOR.
- eret in RUN with no trap: EXL←0; next cycle flush=1, redirect_pc=EPC.
- Traps are not accepted while EXL=1, except overflow. Overflow is always accepted.
- In TRAP state all traps, eret and mtc0 are ignored, because the EX instruction is being flushed.
- Simultaneous trap and mtc0: the trap wins and the mtc0 is dropped. Simultaneous trap and eret: the trap wins.
- IP[15:10] = synchronized hw_int, updated every cycle and not latched. Dropping a line before it is taken loses the request.

## Timing
- Reset values: Status=0, Cause=0, EPC=0, flush=0, redirect_pc=0, FSM=RUN, synchronizer flops 0. Reset mid-TRAP aborts the flush immediately.
- hw_int to IP visibility: 2 clk. An interrupt can be accepted on the 3rd rising edge after hw_int rises.
- Trap/eret detected at edge N: CP0 registers are updated at edge N. flush and redirect_pc are valid for exactly the cycle between edges N and N+1.
- Back-to-back: the earliest next acceptance is edge N+2.
- mtc0 write takes effect at the edge. mfc0 in the same cycle returns the old value.

## Configuration
- CP0_TIMER_EN defined:
  - Adds Count(9), which increments every cycle and wraps at 2^32.
  - Adds Compare(11).
  - Timer pending sets when Count==Compare and is cleared by mtc0 to Compare.
  - Timer pending is ORed into IP[15] with hw_int[5].
  - mtc0 to Count loads the value in place of the increment.
- CP0_TIMER_EN undefined: registers 9/11 read 0, writes ignored, IP[15]=hw_int[5] only.

## Structure
- Shared package cp0_pkg holds:
  - register addresses 9/11/12/13/14;
  - ExcCode constants INT=0 and OV=12;
  - Status/Cause bit positions;
  - FSM state encoding.
- Sub-module cp0_int_sync: NUM_HW_INT-wide 2-flop synchronizer with async reset.

## Test plan
- Reset asserted mid-cycle with flush=1 → flush=0 immediately; mfc0 12/13/14 read 0.
- ex_pc=0x0040_0010, ex_overflow=1, BD=0 → next cycle flush=1, redirect_pc=0x8000_0180; EPC=0x0040_0010, ExcCode=12, EXL=1.
- Overflow with BD=1, ex_pc=0x0040_0020 → EPC=0x0040_001C, Cause.BD=1.
- Status=0x0000_0401, hw_int[0] pulse held 3 cycles, ex_valid=1 → trap on 3rd edge, ExcCode=0; with IE=0 → no trap.
- Follow with eret → EXL=0, redirect_pc=EPC for one cycle; a simultaneous mtc0 on the trap cycle leaves the target register unchanged.
- CP0_TIMER_EN: Compare=5 after reset, Status=0x0000_8001 → interrupt taken after Count reaches 5; mtc0 Compare clears IP[15].
